dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, SRAM word-address width.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port DREQ  input  1  core data request.
REQ-005 SHALL have port DADDR  input  32  core byte address.
REQ-006 SHALL have port DRW  input  1  1 = write, 0 = read.
REQ-007 SHALL have port DSIZE  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port DWDATA  input  32  store data, right-aligned.
REQ-009 SHALL have port DRDATA  output  32  load data, right-aligned, zero-extended.
REQ-010 SHALL have port DREADY  output  1  bridge can accept a request this cycle.
REQ-011 SHALL have port DRVALID  output  1  one-cycle pulse, DRDATA valid.
REQ-012 SHALL have port DERR  output  1  sticky misaligned/illegal-access flag.
REQ-013 SHALL have port ERRADDR  output  32  DADDR of first erroring request.
REQ-014 SHALL have port STORE_CNT  output  16  completed-write counter.
REQ-015 SHALL have port MCSN  output  1  SRAM chip select, active-low.
REQ-016 SHALL have port MADDR  output  ADDR_W  SRAM word address = DADDR[ADDR_W+1:2].
REQ-017 SHALL have port MWE  output  1  SRAM write enable.
REQ-018 SHALL have port MBE  output  4  SRAM byte enables.
REQ-019 SHALL have port MDI  output  32  SRAM write data.
REQ-020 SHALL have port MDO  input  32  SRAM read data, valid one cycle after MCSN=0 with MWE=0.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, CAPTURE, ERR.
REQ-022 SHALL assert DREADY only in IDLE; request accepted when DREQ & DREADY; DREQ outside IDLE ignored.
REQ-023 SHALL on acceptance register DADDR, DRW, DSIZE, DWDATA; next state ACCESS if aligned, else ERR.
REQ-024 SHALL treat as misaligned: DSIZE=01 with DADDR[0]=1; DSIZE=10 with DADDR[1:0]!=00; DSIZE=11 always.
REQ-025 SHALL in ACCESS drive MCSN=0, MWE=registered DRW, MADDR, MBE, MDI from registered request; MCSN=1, MWE=0 in all other states.
REQ-026 SHALL generate MBE: byte at offset k -> 1<<k; half at offset 0 -> 0011, offset 2 -> 1100; word -> 1111.
REQ-027 SHALL replicate store data: byte to all four lanes, half to both halves, word unchanged.
REQ-028 SHALL transition ACCESS -> IDLE for writes, ACCESS -> CAPTURE for reads.
REQ-029 SHALL in CAPTURE register MDO shifted right by 8*offset and masked to size into DRDATA, pulse DRVALID next cycle, go IDLE.
REQ-030 SHALL latency: write strobe at accept+1, DREADY again at accept+2; read DRVALID at accept+3, next accept at accept+3.
REQ-031 SHALL in ERR perform no SRAM access, set DERR, latch ERRADDR only if DERR was 0, go IDLE; erroring reads pulse DRVALID next cycle with DRDATA=0.
REQ-032 SHALL increment STORE_CNT once per ACCESS cycle with MWE=1, saturating at 16'hFFFF.
REQ-033 SHALL hold DRDATA between reads.

Reset
REQ-034 SHALL on RESET=1 at a rising edge enter IDLE and clear DRDATA, DRVALID, DERR, ERRADDR, STORE_CNT, and registered request.
REQ-035 SHALL gate MCSN high and MWE low combinationally while RESET=1, so a write in ACCESS during reset is suppressed.
REQ-036 SHALL DERR and ERRADDR cleared only by RESET.

Verification
REQ-037 Word write DADDR=0x10, DWDATA=0x12345678 -> accept+1: MCSN=0, MWE=1, MADDR=4, MBE=1111, MDI=0x12345678; STORE_CNT=1.
REQ-038 Byte write DADDR=0x23, DWDATA=0xAB -> MBE=1000, MDI=0xABABABAB, MADDR=8.
REQ-039 Half read DADDR=0x12, MDO=0xBEEF1234 -> DRVALID at accept+3, DRDATA=0x0000BEEF; DREADY=0 for accept+1..+2.
REQ-040 Word read DADDR=0x06 -> no SRAM access, DERR=1, ERRADDR=0x06, DRDATA=0, DRVALID at accept+2; later error at 0x09 leaves ERRADDR=0x06.
REQ-041 RESET in ACCESS of write -> MWE=0 that cycle, STORE_CNT=0, IDLE, DREADY=1 next cycle.
REQ-042 65537 back-to-back writes -> STORE_CNT holds 0xFFFF.

Source files
------------

// File: rtl/dmem_bridge.sv
// Bridge between a core's byte-addressed data port and a single-cycle synchronous SRAM.
// Handles sub-word alignment, lane replication, misalignment trapping and store counting.
module dmem_bridge #(
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DREQ,
    input  logic [31:0]       DADDR,
    input  logic              DRW,
    input  logic [1:0]        DSIZE,
    input  logic [31:0]       DWDATA,
    output logic [31:0]       DRDATA,
    output logic              DREADY,
    output logic              DRVALID,
    output logic              DERR,
    output logic [31:0]       ERRADDR,
    output logic [15:0]       STORE_CNT,
    output logic              MCSN,
    output logic [ADDR_W-1:0] MADDR,
    output logic              MWE,
    output logic [3:0]        MBE,
    output logic [31:0]       MDI,
    input  logic [31:0]       MDO
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ERR} state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [3:0]  req_be;
    logic [31:0] req_mdi;
    logic [15:0] store_cnt;

    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] mdi_next;
    logic [31:0] rd_shift;
    logic [31:0] rd_data;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        mdi_next   = DWDATA;
        case (DSIZE)
            2'b00: begin
                be_next  = 4'b0001 << DADDR[1:0];
                mdi_next = {4{DWDATA[7:0]}};
            end
            2'b01: begin
                misaligned = DADDR[0];
                be_next    = DADDR[1] ? 4'b1100 : 4'b0011;
                mdi_next   = {2{DWDATA[15:0]}};
            end
            2'b10:   misaligned = |DADDR[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then zero-extend to the access size.
    always_comb begin
        rd_shift = MDO >> {req_addr[1:0], 3'b000};
        case (req_size)
            2'b00:   rd_data = {24'h0, rd_shift[7:0]};
            2'b01:   rd_data = {16'h0, rd_shift[15:0]};
            default: rd_data = rd_shift;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_rw    <= 1'b0;
            req_size  <= '0;
            req_be    <= '0;
            req_mdi   <= '0;
            DRDATA    <= '0;
            DRVALID   <= 1'b0;
            DERR      <= 1'b0;
            ERRADDR   <= '0;
            store_cnt <= '0;
        end else begin
            DRVALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (DREQ) begin
                        req_addr <= DADDR;
                        req_rw   <= DRW;
                        req_size <= DSIZE;
                        req_be   <= be_next;
                        req_mdi  <= mdi_next;
                        state    <= misaligned ? ERR : ACCESS;
                    end
                end
                ACCESS: begin
                    if (req_rw) begin
                        if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
                        state <= IDLE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    DRDATA  <= rd_data;
                    DRVALID <= 1'b1;
                    state   <= IDLE;
                end
                ERR: begin
                    DERR <= 1'b1;
                    if (!DERR) ERRADDR <= req_addr;
                    if (!req_rw) begin
                        DRDATA  <= '0;
                        DRVALID <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the strobes combinationally so a write already in ACCESS never reaches the SRAM.
    assign DREADY    = (state == IDLE);
    assign MCSN      = (state != ACCESS) || RESET;
    assign MWE       = (state == ACCESS) && req_rw && !RESET;
    assign MADDR     = req_addr[ADDR_W+1:2];
    assign MBE       = req_be;
    assign MDI       = req_mdi;
    assign STORE_CNT = store_cnt;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: directed requests push expected SRAM writes and
// load responses; a negedge monitor pops and compares them, including their cycle of arrival.
module tb_dmem_bridge;

    localparam int ADDR_W = 12;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              DREQ = 1'b0;
    logic [31:0]       DADDR = '0;
    logic              DRW = 1'b0;
    logic [1:0]        DSIZE = '0;
    logic [31:0]       DWDATA = '0;
    logic [31:0]       DRDATA;
    logic              DREADY;
    logic              DRVALID;
    logic              DERR;
    logic [31:0]       ERRADDR;
    logic [15:0]       STORE_CNT;
    logic              MCSN;
    logic [ADDR_W-1:0] MADDR;
    logic              MWE;
    logic [3:0]        MBE;
    logic [31:0]       MDI;
    logic [31:0]       MDO = '0;

    dmem_bridge #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW), .DSIZE(DSIZE),
        .DWDATA(DWDATA), .DRDATA(DRDATA), .DREADY(DREADY), .DRVALID(DRVALID), .DERR(DERR),
        .ERRADDR(ERRADDR), .STORE_CNT(STORE_CNT), .MCSN(MCSN), .MADDR(MADDR), .MWE(MWE),
        .MBE(MBE), .MDI(MDI), .MDO(MDO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Synchronous SRAM model: read data appears the cycle after the select.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge CLK) begin
        if (!MCSN) begin
            if (MWE) begin
                for (int b = 0; b < 4; b++)
                    if (MBE[b]) mem[MADDR][8*b +: 8] <= MDI[8*b +: 8];
            end else begin
                MDO <= mem[MADDR];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       di;
        int                due;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            if (DRVALID) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_drvalid", 32'd1, 32'd0);
                end else begin
                    rd_t e;
                    e = rd_q.pop_front();
                    check("drdata", DRDATA, e.data);
                    check("drvalid_cycle", cyc, e.due);
                end
            end
            if (!MCSN && MWE) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("maddr", 32'(MADDR), 32'(w.addr));
                    check("mbe", 32'(MBE), 32'(w.be));
                    check("mdi", MDI, w.di);
                    check("write_cycle", cyc, w.due);
                end
            end
        end
    end

    // Issue one request; returns one time unit after the accepting edge with that edge's cycle number.
    task automatic req(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                       input logic [31:0] wdata, output int acc);
        int n = 0;
        while (!DREADY && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 20) check("dready_timeout", 32'(n), 32'd0);
        DREQ = 1'b1; DADDR = addr; DRW = rw; DSIZE = size; DWDATA = wdata;
        @(posedge CLK); #1;
        acc  = cyc;
        DREQ = 1'b0;
    endtask

    task automatic push_rd(input logic [31:0] data, input int due);
        rd_t e;
        e.data = data; e.due = due;
        rd_q.push_back(e);
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                           input logic [31:0] di, input int due);
        wr_t w;
        w.addr = addr; w.be = be; w.di = di; w.due = due;
        wr_q.push_back(w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[4] = 32'hBEEF1234;
        mem[8] = 32'h11223344;

        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_dready", 32'(DREADY), 32'd1);
        check("rst_drvalid", 32'(DRVALID), 32'd0);
        check("rst_derr", 32'(DERR), 32'd0);
        check("rst_erraddr", ERRADDR, 32'd0);
        check("rst_store_cnt", 32'(STORE_CNT), 32'd0);
        check("rst_drdata", DRDATA, 32'd0);
        check("rst_mcsn", 32'(MCSN), 32'd1);
        check("rst_mwe", 32'(MWE), 32'd0);

        // Half read at offset 2: upper half of the word, busy for two cycles.
        req(32'h12, 1'b0, 2'b01, '0, a);
        push_rd(32'h0000BEEF, a + 2);
        @(negedge CLK);
        check("rd_mcsn", 32'(MCSN), 32'd0);
        check("rd_mwe", 32'(MWE), 32'd0);
        check("rd_maddr", 32'(MADDR), 32'd4);
        check("rd_busy1", 32'(DREADY), 32'd0);
        @(negedge CLK);
        check("rd_busy2", 32'(DREADY), 32'd0);
        check("rd_mcsn_off", 32'(MCSN), 32'd1);
        @(negedge CLK);
        check("rd_ready3", 32'(DREADY), 32'd1);

        // Word write.
        req(32'h10, 1'b1, 2'b10, 32'h12345678, a);
        push_wr(12'd4, 4'b1111, 32'h12345678, a);
        @(negedge CLK);
        check("wr_mwe", 32'(MWE), 32'd1);
        @(negedge CLK);
        check("wr_store_cnt", 32'(STORE_CNT), 32'd1);
        check("wr_ready2", 32'(DREADY), 32'd1);
        check("drdata_hold", DRDATA, 32'h0000BEEF);

        req(32'h10, 1'b0, 2'b10, '0, a);
        push_rd(32'h12345678, a + 2);

        // Byte write to lane 3 with replication, then sub-word reads of the merged word.
        req(32'h23, 1'b1, 2'b00, 32'h000000AB, a);
        push_wr(12'd8, 4'b1000, 32'hABABABAB, a);
        req(32'h23, 1'b0, 2'b00, '0, a);
        push_rd(32'h000000AB, a + 2);
        req(32'h21, 1'b0, 2'b00, '0, a);
        push_rd(32'h00000033, a + 2);
        req(32'h20, 1'b0, 2'b01, '0, a);
        push_rd(32'h00003344, a + 2);
        req(32'h22, 1'b1, 2'b01, 32'h12345678, a);
        push_wr(12'd8, 4'b1100, 32'h56785678, a);
        req(32'h20, 1'b0, 2'b10, '0, a);
        push_rd(32'h56783344, a + 2);
        @(negedge CLK);
        @(negedge CLK);
        check("store_cnt_3", 32'(STORE_CNT), 32'd3);

        // Misaligned word read: no SRAM access, zero data one cycle early, error latched.
        req(32'h06, 1'b0, 2'b10, '0, a);
        push_rd(32'h0, a + 1);
        @(negedge CLK);
        check("err_no_access", 32'(MCSN), 32'd1);
        @(negedge CLK);
        check("err_derr", 32'(DERR), 32'd1);
        check("err_erraddr", ERRADDR, 32'h06);
        check("err_ready", 32'(DREADY), 32'd1);

        req(32'h09, 1'b1, 2'b01, 32'hFFFF, a);
        req(32'h00, 1'b0, 2'b11, '0, a);
        push_rd(32'h0, a + 1);
        @(negedge CLK);
        @(negedge CLK);
        check("err2_erraddr", ERRADDR, 32'h06);
        check("err2_derr", 32'(DERR), 32'd1);
        check("err2_store_cnt", 32'(STORE_CNT), 32'd3);

        // Reset arriving while a write is in ACCESS.
        req(32'h30, 1'b1, 2'b10, 32'hDEAD0000, a);
        RESET = 1'b1;
        @(negedge CLK);
        check("rstacc_mwe", 32'(MWE), 32'd0);
        check("rstacc_mcsn", 32'(MCSN), 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rstacc_dready", 32'(DREADY), 32'd1);
        check("rstacc_store_cnt", 32'(STORE_CNT), 32'd0);
        check("rstacc_derr", 32'(DERR), 32'd0);
        check("rstacc_erraddr", ERRADDR, 32'd0);
        check("rstacc_mem", mem[12], 32'd0);

        // Counter saturation, started just below the limit.
        force dut.store_cnt = 16'hFFFD;
        @(posedge CLK); #1;
        release dut.store_cnt;
        for (int i = 0; i < 4; i++) begin
            req(32'h40 + 32'(4 * i), 1'b1, 2'b10, 32'(i), a);
            push_wr(12'(16 + i), 4'b1111, 32'(i), a);
            @(negedge CLK);
            @(negedge CLK);
            if (i == 0) check("sat_cnt_fffe", 32'(STORE_CNT), 32'h0000FFFE);
        end
        check("sat_cnt_ffff", 32'(STORE_CNT), 32'h0000FFFF);

        repeat (5) @(negedge CLK);
        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
